// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with a single-entry registered result slot.
// Define ALU_MUL_EN to add the iterative shift-add multiply on opcode 1010.
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_ovf,
    output logic             out_err
);
    localparam int M = WIDTH - 1;
    logic [WIDTH-1:0] w_res, w_ld_res;
    logic             w_c, w_v, w_e, w_ld_c, w_ld_v, w_ld_e, w_load;
    logic             r_valid, r_carry, r_zero, r_neg, r_ovf, r_err;
    logic [WIDTH-1:0] r_result;
    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_e   = 1'b0;
        case (in_op)
            4'h0: begin
                {w_c, w_res} = {1'b0, in_a} + {1'b0, in_b};
                w_v = (in_a[M] == in_b[M]) && (w_res[M] != in_a[M]);
            end
            4'h1: begin
                {w_c, w_res} = {1'b0, in_a} - {1'b0, in_b};
                w_v = (in_a[M] != in_b[M]) && (w_res[M] != in_a[M]);
            end
            4'h2: w_res = in_a & in_b;
            4'h3: w_res = in_a | in_b;
            4'h4: w_res = in_a ^ in_b;
            4'h5: w_res = ~in_a;
            4'h6: begin
                {w_c, w_res} = {1'b0, in_a} + (WIDTH+1)'(1);
                w_v = !in_a[M] && w_res[M];
            end
            4'h7: begin
                {w_c, w_res} = {1'b0, in_a} - (WIDTH+1)'(1);
                w_v = in_a[M] && !w_res[M];
            end
            4'h8: {w_c, w_res} = {in_a, 1'b0};
            4'h9: {w_res, w_c} = {1'b0, in_a};
`ifdef ALU_MUL_EN
            4'hA: w_res = '0;
`endif
            default: w_e = 1'b1;
        endcase
    end
`ifdef ALU_MUL_EN
    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
    localparam int CW = $clog2(WIDTH);
    logic [1:0]         r_state;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_a, r_b;
    logic               w_mul_ld;
    assign in_ready = (r_state == IDLE) && (!r_valid || out_ready);
    assign w_mul_ld = (r_state == DONE) && (!r_valid || out_ready);
    assign w_load   = w_mul_ld || (in_valid && in_ready && in_op != 4'hA);
    assign w_ld_res = w_mul_ld ? r_acc[WIDTH-1:0] : w_res;
    assign w_ld_c   = w_mul_ld ? |r_acc[2*WIDTH-1:WIDTH] : w_c;
    assign w_ld_v   = !w_mul_ld && w_v;
    assign w_ld_e   = !w_mul_ld && w_e;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_a     <= '0;
            r_b     <= '0;
        end else begin
            case (r_state)
                IDLE: if (in_valid && in_ready && in_op == 4'hA) begin
                    r_state <= BUSY;
                    r_cnt   <= '0;
                    r_acc   <= '0;
                    r_a     <= in_a;
                    r_b     <= in_b;
                end
                BUSY: begin
                    if (r_b[r_cnt]) r_acc <= r_acc + ({{WIDTH{1'b0}}, r_a} << r_cnt);
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(M)) r_state <= DONE;
                end
                DONE: if (w_mul_ld) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
`else
    assign in_ready = !r_valid || out_ready;
    assign w_load   = in_valid && in_ready;
    assign w_ld_res = w_res;
    assign w_ld_c   = w_c;
    assign w_ld_v   = w_v;
    assign w_ld_e   = w_e;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
            r_neg    <= 1'b0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
        end else if (w_load) begin
            r_valid  <= 1'b1;
            r_result <= w_ld_res;
            r_carry  <= w_ld_c;
            r_zero   <= w_ld_res == '0;
            r_neg    <= w_ld_res[M];
            r_ovf    <= w_ld_v;
            r_err    <= w_ld_e;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end
    assign out_valid  = r_valid;
    assign out_result = r_result;
    assign out_carry  = r_carry;
    assign out_zero   = r_zero;
    assign out_neg    = r_neg;
    assign out_ovf    = r_ovf;
    assign out_err    = r_err;
endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, handshaked successor to the team's 4-bit combinational ALU. It accepts one operation per transaction on a valid/ready input and registers the result with carry, zero, negative, overflow and error flags in a single-entry output slot. With `ALU_MUL_EN` it also provides an iterative shift-add multiply. It sits between an operand-issue stage and a result consumer that may stall.

## Interface
Parameters:
- `WIDTH`, default 8, operand/result width; legal values ≥ 2.

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: operation request.
- `in_ready` out 1: block can accept a request this cycle.
- `in_op` in 4: opcode.
- `in_a` in WIDTH: operand A, unsigned/two's complement.
- `in_b` in WIDTH: operand B.
- `out_valid` out 1: output slot holds a result.
- `out_ready` in 1: consumer takes the result.
- `out_result` out WIDTH: result.
- `out_carry` out 1: carry, borrow, or shifted-out bit.
- `out_zero` out 1: `out_result == 0`.
- `out_neg` out 1: `out_result[WIDTH-1]`.
- `out_ovf` out 1: signed overflow.
- `out_err` out 1: illegal opcode.

Clock is `clk`. Reset is `rst`, asynchronous, active-high.

## Operation
- Accept when `in_valid && in_ready`. `in_ready = (state==IDLE) && (!out_valid || out_ready)`.

Opcodes:
- 0000 ADD: A+B; carry = carry-out.
- 0001 SUB: A−B; carry = borrow (A<B unsigned).
- 0010 AND, 0011 OR, 0100 XOR, 0101 NOT A: carry = 0, ovf = 0.
- 0110 INC: A+1; carry = carry-out.
- 0111 DEC: A−1; carry = borrow (A==0).
- 1000 SHL: A<<1; carry = A[WIDTH-1].
- 1001 SHR (logical): A>>1; carry = A[0].
- 1010 MUL (only with `ALU_MUL_EN`): result = low WIDTH bits of A×B; carry = 1 if the high WIDTH bits ≠ 0; ovf = 0.
- Any other opcode: result 0, err = 1, carry/ovf/neg = 0, zero = 1.

Flags:
- ovf for ADD/INC/SUB/DEC is two's-complement overflow. It is 0 for all other opcodes.
- zero and neg are always derived from the final result.

State machine:
- IDLE: single-cycle ops go straight to the output register. MUL goes to BUSY with counter = 0, product = 0, and A and B latched.
- BUSY: each cycle, if B[count] then product += A<<count (2·WIDTH-bit accumulator); count++. After the step with count == WIDTH−1, go to DONE.
- DONE: if `!out_valid || out_ready`, load the output and go to IDLE. Otherwise hold.

Output slot:
- Loading sets `out_valid`.
- `out_ready` with no simultaneous load clears it.
- Simultaneous drain and load replaces the contents and keeps `out_valid` = 1.
- Outputs are stable while `out_valid && !out_ready`.
- Inputs are ignored while `in_ready` = 0.

Reset:
- All outputs 0 and state IDLE. `in_ready` reads 1 after reset since the slot is empty.
- Reset during BUSY/DONE aborts the multiply and discards the partial product.

## Timing
- Single-cycle ops: accepted at edge N, `out_valid` = 1 after edge N, so the result is visible in cycle N+1.
- Back-to-back: with `out_ready` held at 1, one op accepted and one result delivered every cycle.
- MUL: accept at edge N. BUSY steps occupy edges N+1..N+WIDTH. The DONE load occurs at edge N+WIDTH+1 if the slot is free. `in_ready` is 0 from edge N until that load.
- Stall: `out_valid && !out_ready` forces `in_ready` = 0 and holds DONE indefinitely.
- No combinational path from `in_*` to `out_*`. The only combinational path from `out_ready` is to `in_ready`.

## Configuration
- `ALU_MUL_EN` defined: opcode 1010 performs the iterative multiply, and the BUSY/DONE states and 2·WIDTH accumulator are present.
- `ALU_MUL_EN` undefined: no multiply hardware and no BUSY/DONE states. Opcode 1010 is illegal (err = 1, single cycle), and `in_ready = !out_valid || out_ready`.

## Test plan
- Reset asserted mid-operation: all outputs go to 0 asynchronously. After release `in_ready` = 1 and `out_valid` = 0.
- WIDTH=8, ADD 0xFF+0x01: result 0x00, carry 1, zero 1, ovf 0. ADD 0x7F+0x01: result 0x80, neg 1, ovf 1.
- WIDTH=8, SUB 0x00−0x01: result 0xFF, carry 1, neg 1. DEC 0x80: result 0x7F, ovf 1. SHR 0x01: result 0x00, carry 1, zero 1.
- Ten back-to-back ops with `out_ready` = 1: ten results in order on consecutive cycles. Hold `out_ready` = 0 for 3 cycles: `in_ready` = 0 and the result is unchanged.
- `ALU_MUL_EN`, WIDTH=8, MUL 0x10×0x11: result 0x10, carry 1, `out_valid` at edge N+9. Reset at edge N+4 aborts the multiply with no result.
- Without `ALU_MUL_EN`, opcode 1010 and opcode 1111: result 0, err 1, zero 1, one-cycle latency.
